// File: rtl/input_sync_debounce.sv
// ---------------------------------------------------------------------------
// input_sync_debounce
//
// Purpose:
//   Multi-channel conditioner for push-buttons and switches. Every channel
//   runs its asynchronous pin through an N-flop synchroniser, a debounce
//   counter and a registered level/edge-pulse stage. Channels share nothing
//   but the clock and reset.
//
// Parameters:
//   WIDTH           - number of independent channels
//   SYNC_STAGES     - synchroniser depth per channel (2..4)
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to change the level
//                     (>= 1; 1 disables filtering)
//   CNT_W           - debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   din        in   [WIDTH]   raw asynchronous pins
//   edge_sel   in   [2*WIDTH] per-channel edge mode, bits [2i+1:2i]:
//                   00 rise, 01 fall, 10 both, 11 none (quasi-static)
//   level_out  out  [WIDTH]   debounced level
//   pulse_out  out  [WIDTH]   one-clock pulse on a selected level change
//   any_pulse  out  OR of pulse_out, registered alongside it
//   toggle_out out  [WIDTH]   push-on/push-off state, flips with each pulse
//                   (present only when INPUT_SYNC_TOGGLE_EN is defined)
//
// Optional feature macro: INPUT_SYNC_TOGGLE_EN
// ---------------------------------------------------------------------------
module input_sync_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   edge_sel,
    output logic [WIDTH-1:0]     level_out,
    output logic [WIDTH-1:0]     pulse_out,
`ifdef INPUT_SYNC_TOGGLE_EN
    output logic [WIDTH-1:0]     toggle_out,
`endif
    output logic                 any_pulse
);

    // Terminal count: a mismatch seen while the counter sits here commits.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_pulse_next;
    logic [WIDTH-1:0] r_pulse;
    logic             r_any;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_level;
            logic                   w_sync;
            logic                   w_mismatch;
            logic                   w_commit;
            logic                   w_edge_ok;
            logic [1:0]             w_sel;

            assign w_sync     = r_sync[SYNC_STAGES-1];
            assign w_mismatch = (w_sync != r_level);
            assign w_commit   = w_mismatch && (r_cnt == CNT_MAX);
            assign w_sel      = edge_sel[2*gi +: 2];

            // Edge qualification looks at the level being committed (w_sync),
            // so the pulse lines up with the level_out change.
            always_comb begin
                w_edge_ok = 1'b0;
                case (w_sel)
                    2'b00:   w_edge_ok = w_sync;
                    2'b01:   w_edge_ok = ~w_sync;
                    2'b10:   w_edge_ok = 1'b1;
                    default: w_edge_ok = 1'b0;
                endcase
            end

            assign w_pulse_next[gi] = w_commit && w_edge_ok;
            assign w_level[gi]      = r_level;

            // Synchroniser: s[0] captures the pin, the last stage is the
            // first one considered safe to use.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], din[gi]};
                end
            end

            // Debounce: any return to the current level restarts the count,
            // so the counter is bounded by CNT_MAX and cannot wrap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (!w_mismatch) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_cnt   <= '0;
                    r_level <= w_sync;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Pulses and their OR are registered in parallel so any_pulse is
    // cycle-aligned with pulse_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse <= '0;
            r_any   <= 1'b0;
        end else begin
            r_pulse <= w_pulse_next;
            r_any   <= |w_pulse_next;
        end
    end

    assign level_out = w_level;
    assign pulse_out = r_pulse;
    assign any_pulse = r_any;

`ifdef INPUT_SYNC_TOGGLE_EN
    logic [WIDTH-1:0] r_toggle;

    // Flips on the same edge that raises pulse_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle <= '0;
        end else begin
            r_toggle <= r_toggle ^ w_pulse_next;
        end
    end

    assign toggle_out = r_toggle;
`endif

endmodule

// File: tb/tb_input_sync_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_sync_debounce
//
// Directed bench for input_sync_debounce at WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, CNT_W=3. The stimulus process pushes each expected
// pulse event (cycle, pulse vector, level vector) into a queue; a monitor
// on the falling edge pops one entry whenever the DUT shows a pulse.
// With a pin change applied after edge k, the first sampling edge is k+1
// and the commit lands on edge k+6 (2 sync stages + 4 debounce edges).
// ---------------------------------------------------------------------------
module tb_input_sync_debounce;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] din      = 4'b1111;
    logic [7:0] edge_sel = 8'h00;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic       any_pulse;
`ifdef INPUT_SYNC_TOGGLE_EN
    logic [3:0] toggle_out;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [3:0] level;
    } exp_t;

    exp_t exp_q[$];

    input_sync_debounce #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .edge_sel  (edge_sel),
        .level_out (level_out),
        .pulse_out (pulse_out),
`ifdef INPUT_SYNC_TOGGLE_EN
        .toggle_out(toggle_out),
`endif
        .any_pulse (any_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] p, input logic [3:0] l);
        exp_t e;
        e.cyc   = c;
        e.pulse = p;
        e.level = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every visible pulse consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if ((pulse_out !== 4'b0000) || (any_pulse !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {27'b0, any_pulse, pulse_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("pulse event: cycle %0d pulse_out=%b any_pulse=%b level_out=%b (expected cycle %0d pulse %b level %b)",
                         cyc, pulse_out, any_pulse, level_out, e.cyc, e.pulse, e.level);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_out", {28'b0, pulse_out}, {28'b0, e.pulse});
                check("any_pulse", {31'b0, any_pulse}, 32'd1);
                check("level_at_pulse", {28'b0, level_out}, {28'b0, e.level});
            end
        end
    end

    initial begin : stim
        int k;

        // Reset held for three edges with all pins high.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_level", {28'b0, level_out}, 32'd0);
            check("reset_pulse", {28'b0, pulse_out}, 32'd0);
            check("reset_any", {31'b0, any_pulse}, 32'd0);
`ifdef INPUT_SYNC_TOGGLE_EN
            check("reset_toggle", {28'b0, toggle_out}, 32'd0);
`endif
        end
        rst = 1'b0;
        k = cyc;
        expect_pulse(k + 6, 4'b1111, 4'b1111);
        wait_until(k + 5);
        check("level_before_first_commit", {28'b0, level_out}, 32'd0);
        wait_until(k + 7);
        check("level_after_release", {28'b0, level_out}, 32'hF);

        // All pins low; falling commits do not pulse with edge_sel = 00.
        din = 4'b0000;
        k = cyc;
        wait_until(k + 8);
        check("level_all_low", {28'b0, level_out}, 32'd0);

        // Three-cycle glitch on channel 0 is rejected.
        k = cyc;
        din = 4'b0001;
        wait_until(k + 3);
        din = 4'b0000;
        wait_until(k + 12);
        check("glitch3_level", {28'b0, level_out}, 32'd0);

        // Four-cycle pulse on channel 0 just commits, then falls back.
        k = cyc;
        din = 4'b0001;
        expect_pulse(k + 6, 4'b0001, 4'b0001);
        wait_until(k + 4);
        din = 4'b0000;
        wait_until(k + 12);
        check("glitch4_level_back_low", {28'b0, level_out}, 32'd0);

        // Bounce on channel 1: 1,0,1,1,1,... commit restarts after the 0.
        k = cyc;
        din = 4'b0010;
        wait_until(k + 1);
        din = 4'b0000;
        wait_until(k + 2);
        din = 4'b0010;
        expect_pulse(k + 8, 4'b0010, 4'b0010);
        wait_until(k + 7);
        check("bounce_level_before", {28'b0, level_out}, 32'd0);
        wait_until(k + 9);
        check("bounce_level_after", {28'b0, level_out}, 32'h2);
        din = 4'b0000;
        k = cyc;
        wait_until(k + 8);
        check("bounce_level_back_low", {28'b0, level_out}, 32'd0);

        // Edge modes: ch0 rise, ch1 fall, ch2 both, ch3 none.
        edge_sel = 8'b11_10_01_00;
        k = cyc;
        din = 4'b1111;
        expect_pulse(k + 6, 4'b0101, 4'b1111);
        wait_until(k + 8);
        din = 4'b0000;
        expect_pulse(k + 14, 4'b0110, 4'b0000);
        wait_until(k + 16);
        check("edge_modes_level_low", {28'b0, level_out}, 32'd0);

        // Reset two counts into a debounce on channel 2 restarts it.
        edge_sel = 8'h00;
        k = cyc;
        din = 4'b0100;
        wait_until(k + 4);
        rst = 1'b1;
        wait_until(k + 5);
        rst = 1'b0;
        check("mid_reset_level", {28'b0, level_out}, 32'd0);
`ifdef INPUT_SYNC_TOGGLE_EN
        check("mid_reset_toggle", {28'b0, toggle_out}, 32'd0);
`endif
        expect_pulse(k + 11, 4'b0100, 4'b0100);
        wait_until(k + 10);
        check("mid_reset_level_before", {28'b0, level_out}, 32'd0);
        wait_until(k + 12);
        check("mid_reset_level_after", {28'b0, level_out}, 32'h4);
        din = 4'b0000;
        k = cyc;
        wait_until(k + 8);
        check("mid_reset_level_back_low", {28'b0, level_out}, 32'd0);

        // Three clean presses on channel 0 from a fresh reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int p = 0; p < 3; p++) begin
            k = cyc;
            din = 4'b0001;
            expect_pulse(k + 6, 4'b0001, 4'b0001);
            wait_until(k + 7);
`ifdef INPUT_SYNC_TOGGLE_EN
            check("toggle_out0", {31'b0, toggle_out[0]}, (p % 2 == 0) ? 32'd1 : 32'd0);
`endif
            wait_until(k + 8);
            din = 4'b0000;
            wait_until(k + 16);
        end

        tick(3);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
